// File: rtl/rx_ctrl_pkg.sv
// Shared constants for the PSK receive acquisition sequencer: state encodings,
// default loop thresholds/timeouts, and the counter-width helper.
package rx_ctrl_pkg;

  localparam logic [1:0] ST_RESTART = 2'd0;
  localparam logic [1:0] ST_ACQ     = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;
  localparam logic [1:0] ST_FRAME   = 2'd3;

  localparam int DEF_LOCK_SYMS     = 16;
  localparam int DEF_UNLOCK_SYMS   = 32;
  localparam int DEF_ACQ_TIMEOUT   = 4096;
  localparam int DEF_FRAME_TIMEOUT = 2048;
  localparam int DEF_RST_CYCLES    = 64;

  // Bits needed to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rx_lock_detect.sv
// Costas phase-error lock detector: |e| against threshold, consecutive in/out
// run counters, and single-cycle lock/unlock hits on the qualifying symbol.
module rx_lock_detect
  import rx_ctrl_pkg::*;
#(
  parameter int LOCK_SYMS   = DEF_LOCK_SYMS,
  parameter int UNLOCK_SYMS = DEF_UNLOCK_SYMS
) (
  input  logic               clk_32M768,
  input  logic               rst_32M768,
  input  logic               clr,
  input  logic               sym_ce,
  input  logic signed [15:0] costas_err,
  input  logic        [15:0] lock_thr,
  output logic               lock_hit,
  output logic               unlock_hit
);

  localparam int IN_W  = cnt_width(LOCK_SYMS);
  localparam int OUT_W = cnt_width(UNLOCK_SYMS);
  localparam logic [IN_W-1:0]  IN_MAX   = IN_W'(LOCK_SYMS);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(LOCK_SYMS - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(UNLOCK_SYMS);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(UNLOCK_SYMS - 1);

  logic [15:0]      abs_e;
  logic             in_thr;
  logic [IN_W-1:0]  in_run_q, in_run_d;
  logic [OUT_W-1:0] out_run_q, out_run_d;

  // -32768 has no positive twin in 16 bits, so it clamps to 32767.
  always_comb begin
    if (costas_err[15] && (costas_err[14:0] == 15'd0)) begin
      abs_e = 16'h7fff;
    end else if (costas_err[15]) begin
      abs_e = $unsigned(-costas_err);
    end else begin
      abs_e = $unsigned(costas_err);
    end
  end

  assign in_thr = (abs_e < lock_thr);

  always_comb begin
    in_run_d  = in_run_q;
    out_run_d = out_run_q;
    if (clr) begin
      in_run_d  = '0;
      out_run_d = '0;
    end else if (sym_ce) begin
      if (in_thr) begin
        in_run_d  = (in_run_q == IN_MAX) ? in_run_q : in_run_q + 1'b1;
        out_run_d = '0;
      end else begin
        in_run_d  = '0;
        out_run_d = (out_run_q == OUT_MAX) ? out_run_q : out_run_q + 1'b1;
      end
    end
  end

  assign lock_hit   = !clr && sym_ce &&  in_thr && (in_run_q  >= IN_LAST);
  assign unlock_hit = !clr && sym_ce && !in_thr && (out_run_q >= OUT_LAST);

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      in_run_q  <= '0;
      out_run_q <= '0;
    end else begin
      in_run_q  <= in_run_d;
      out_run_q <= out_run_d;
    end
  end

endmodule

// File: rtl/rx_acq_ctrl.sv
// Acquisition/tracking sequencer: gear-shifts Costas/Gardner loop gains and
// restarts the loops on acquisition timeout or loss of lock.
module rx_acq_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int LOCK_SYMS     = DEF_LOCK_SYMS,
  parameter int UNLOCK_SYMS   = DEF_UNLOCK_SYMS,
  parameter int ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT,
  parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
  parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
  input  logic               clk_32M768,
  input  logic               rst_32M768,
  input  logic               sym_ce,
  input  logic signed [15:0] costas_err,
  input  logic        [15:0] lock_thr,
  input  logic               SD_flag,
  input  logic               PD_flag,
  input  logic               data_tvalid,
  input  logic               data_tlast,
  input  logic        [3:0]  FB_SHIFT_ACQ,
  input  logic        [3:0]  FB_SHIFT_TRK,
  input  logic        [3:0]  GD_SHIFT_ACQ,
  input  logic        [3:0]  GD_SHIFT_TRK,
  output logic        [3:0]  FEEDBACK_SHIFT,
  output logic        [3:0]  GARDNER_SHIFT,
  output logic               loop_rst,
  output logic               locked,
  output logic        [1:0]  state,
  output logic               frame_done,
  output logic               frame_err,
  output logic        [7:0]  restart_cnt
);

  localparam int CNT_W = cnt_width(max3(ACQ_TIMEOUT, FRAME_TIMEOUT, RST_CYCLES));
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST   = CNT_W'(ACQ_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fb_q, fb_d, gd_q, gd_d;
  logic             loop_rst_q, loop_rst_d;
  logic             locked_q, locked_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       restart_cnt_q, restart_cnt_d;
  logic             lock_hit, unlock_hit;

  rx_lock_detect #(
    .LOCK_SYMS   (LOCK_SYMS),
    .UNLOCK_SYMS (UNLOCK_SYMS)
  ) u_lock_detect (
    .clk_32M768 (clk_32M768),
    .rst_32M768 (rst_32M768),
    .clr        (state_q == ST_RESTART),
    .sym_ce     (sym_ce),
    .costas_err (costas_err),
    .lock_thr   (lock_thr),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      ST_RESTART: begin
        if (cnt_q == RST_LAST) state_d = ST_ACQ;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_ACQ: begin
        // Lock is checked first so it wins a tie with the timeout symbol.
        if (lock_hit)                            state_d = ST_TRACK;
        else if (sym_ce && (cnt_q == ACQ_LAST))  state_d = ST_RESTART;
        else if (sym_ce)                         cnt_d   = cnt_q + 1'b1;
      end
      ST_TRACK: begin
        if (unlock_hit)                          state_d = ST_RESTART;
        else if (sym_ce && SD_flag && PD_flag)   state_d = ST_FRAME;
      end
      default: begin
        if (unlock_hit) begin
          frame_err_d = 1'b1;
          state_d     = ST_RESTART;
        end else if (data_tvalid && data_tlast) begin
          frame_done_d = 1'b1;
          state_d      = ST_TRACK;
        end else if (sym_ce && (cnt_q == FRAME_LAST)) begin
          frame_err_d = 1'b1;
          state_d     = ST_TRACK;
        end else if (sym_ce) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Gains are re-selected only on the two gear-shift transitions.
  always_comb begin
    fb_d = fb_q;
    gd_d = gd_q;
    if ((state_q == ST_RESTART) && (state_d == ST_ACQ)) begin
      fb_d = FB_SHIFT_ACQ;
      gd_d = GD_SHIFT_ACQ;
    end else if ((state_q == ST_ACQ) && (state_d == ST_TRACK)) begin
      fb_d = FB_SHIFT_TRK;
      gd_d = GD_SHIFT_TRK;
    end
  end

  always_comb begin
    loop_rst_d    = (state_d == ST_RESTART);
    locked_d      = (state_d == ST_TRACK) || (state_d == ST_FRAME);
    restart_cnt_d = restart_cnt_q;
    if ((state_d == ST_RESTART) && (state_q != ST_RESTART) && (restart_cnt_q != 8'hff))
      restart_cnt_d = restart_cnt_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      state_q       <= ST_RESTART;
      cnt_q         <= '0;
      fb_q          <= '0;
      gd_q          <= '0;
      loop_rst_q    <= 1'b1;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      restart_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fb_q          <= fb_d;
      gd_q          <= gd_d;
      loop_rst_q    <= loop_rst_d;
      locked_q      <= locked_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      restart_cnt_q <= restart_cnt_d;
    end
  end

  assign state          = state_q;
  assign FEEDBACK_SHIFT = fb_q;
  assign GARDNER_SHIFT  = gd_q;
  assign loop_rst       = loop_rst_q;
  assign locked         = locked_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign restart_cnt    = restart_cnt_q;

endmodule

// File: tb/tb_rx_acq_ctrl.sv
// Directed bench for rx_acq_ctrl: expected snapshots are queued as stimulus is
// driven and popped/compared on the falling edge after the DUT responds.
module tb_rx_acq_ctrl;
  import rx_ctrl_pkg::*;

  localparam logic [3:0] FA = 4'h3;
  localparam logic [3:0] FT = 4'h9;
  localparam logic [3:0] GA = 4'h5;
  localparam logic [3:0] GT = 4'hC;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sym_ce = 1'b0;
  logic signed [15:0] err = 16'sd0;
  logic        [15:0] thr = 16'd100;
  logic               sd = 1'b0, pd = 1'b0, tv = 1'b0, tl = 1'b0;
  logic        [3:0]  fb, gd;
  logic               loop_rst, locked, frame_done, frame_err;
  logic        [1:0]  state;
  logic        [7:0]  restart_cnt;

  int          per = 32;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_rc = 8'd0;
  logic [31:0] exp_q[$];

  rx_acq_ctrl dut (
    .clk_32M768     (clk),
    .rst_32M768     (rst),
    .sym_ce         (sym_ce),
    .costas_err     (err),
    .lock_thr       (thr),
    .SD_flag        (sd),
    .PD_flag        (pd),
    .data_tvalid    (tv),
    .data_tlast     (tl),
    .FB_SHIFT_ACQ   (FA),
    .FB_SHIFT_TRK   (FT),
    .GD_SHIFT_ACQ   (GA),
    .GD_SHIFT_TRK   (GT),
    .FEEDBACK_SHIFT (fb),
    .GARDNER_SHIFT  (gd),
    .loop_rst       (loop_rst),
    .locked         (locked),
    .state          (state),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .restart_cnt    (restart_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [1:0] st, input logic lk, input logic lr,
                                     input logic [3:0] f, input logic [3:0] g,
                                     input logic fd, input logic fe, input logic [7:0] rc);
    return {10'd0, st, lk, lr, f, g, fd, fe, rc};
  endfunction

  function automatic logic [31:0] snap();
    return {10'd0, state, locked, loop_rst, fb, gd, frame_done, frame_err, restart_cnt};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Each symbol: idle cycles first, then the strobe, so a check right after
  // the call sees the edge that consumed the last symbol.
  task automatic sym_burst(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (per - 1) tick();
      sym_ce = 1'b1;
      tick();
      sym_ce = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_rc = 8'd0;
    expect_v(mk(ST_RESTART, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0));
    tick();
    check("reset_values", snap());
    rst = 1'b0;
  endtask

  task automatic wait_acq(input string tag);
    int n;
    n = 0;
    expect_v(32'd64);
    expect_v(mk(ST_ACQ, 1'b0, 1'b0, FA, GA, 1'b0, 1'b0, exp_rc));
    while ((loop_rst === 1'b1) && (n < 200)) begin
      n++;
      tick();
    end
    check({tag, "_rst_hold"}, 32'(n));
    check({tag, "_acq_entry"}, snap());
  endtask

  task automatic enter_frame(input string tag);
    sd = 1'b1; pd = 1'b1;
    expect_v(mk(ST_FRAME, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(1);
    check(tag, snap());
    sd = 1'b0; pd = 1'b0;
  endtask

  initial begin
    // Lock acquisition at a slow symbol rate.
    do_reset();
    wait_acq("t1");
    err = 16'sd0; thr = 16'd100; per = 32;
    expect_v(mk(ST_ACQ, 1'b0, 1'b0, FA, GA, 1'b0, 1'b0, exp_rc));
    sym_burst(15);
    check("acq_15_syms", snap());
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(1);
    check("lock_16th_sym", snap());

    // Acquisition timeout at symbol 4096.
    per = 2;
    do_reset();
    wait_acq("t2");
    err = 16'sd500;
    expect_v(mk(ST_ACQ, 1'b0, 1'b0, FA, GA, 1'b0, 1'b0, exp_rc));
    sym_burst(4095);
    check("acq_4095_syms", snap());
    exp_rc = 8'd1;
    expect_v(mk(ST_RESTART, 1'b0, 1'b1, FA, GA, 1'b0, 1'b0, exp_rc));
    sym_burst(1);
    check("acq_timeout", snap());
    wait_acq("t2b");

    // Lock on the same symbol as the timeout wins.
    sym_burst(4080);
    err = 16'sd0;
    expect_v(mk(ST_ACQ, 1'b0, 1'b0, FA, GA, 1'b0, 1'b0, exp_rc));
    sym_burst(15);
    check("acq_4095_mixed", snap());
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(1);
    check("lock_beats_timeout", snap());

    // Unlock needs 32 consecutive bad symbols.
    err = 16'sd500;
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(31);
    check("track_31_bad", snap());
    err = 16'sd0;
    sym_burst(1);
    err = -16'sd500;
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(31);
    check("track_31_bad_again", snap());
    exp_rc = exp_rc + 8'd1;
    expect_v(mk(ST_RESTART, 1'b0, 1'b1, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(1);
    check("unlock_32nd_bad", snap());

    // Frame completes with tlast after 100 symbols.
    wait_acq("t4");
    err = 16'sd0;
    sym_burst(16);
    enter_frame("frame_entry");
    expect_v(mk(ST_FRAME, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(100);
    check("frame_100_syms", snap());
    tv = 1'b1; tl = 1'b1;
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b1, 1'b0, exp_rc));
    tick();
    check("frame_done_pulse", snap());
    tv = 1'b0; tl = 1'b0;
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    tick();
    check("frame_done_clear", snap());

    // Frame timeout; tlast without tvalid is ignored.
    enter_frame("frame_entry2");
    tl = 1'b1;
    expect_v(mk(ST_FRAME, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    tick();
    check("tlast_no_tvalid", snap());
    tl = 1'b0;
    expect_v(mk(ST_FRAME, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(2047);
    check("frame_2047_syms", snap());
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b1, exp_rc));
    sym_burst(1);
    check("frame_timeout_err", snap());
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    tick();
    check("frame_err_clear", snap());

    // Unlock and tlast together: unlock wins.
    enter_frame("frame_entry3");
    err = 16'sd500;
    expect_v(mk(ST_FRAME, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(31);
    check("frame_31_bad", snap());
    repeat (per - 1) tick();
    sym_ce = 1'b1; tv = 1'b1; tl = 1'b1;
    exp_rc = exp_rc + 8'd1;
    expect_v(mk(ST_RESTART, 1'b0, 1'b1, FT, GT, 1'b0, 1'b1, exp_rc));
    tick();
    check("unlock_beats_tlast", snap());
    sym_ce = 1'b0; tv = 1'b0; tl = 1'b0;

    // Reset mid-operation, then the saturating abs and threshold edge.
    do_reset();
    wait_acq("t8");
    thr = 16'd32767; err = -16'sd32768;
    expect_v(mk(ST_ACQ, 1'b0, 1'b0, FA, GA, 1'b0, 1'b0, exp_rc));
    sym_burst(40);
    check("min_neg_no_lock", snap());
    thr = 16'd100; err = 16'sd100;
    expect_v(mk(ST_ACQ, 1'b0, 1'b0, FA, GA, 1'b0, 1'b0, exp_rc));
    sym_burst(20);
    check("err_eq_thr_no_lock", snap());
    err = -16'sd99;
    expect_v(mk(ST_TRACK, 1'b1, 1'b0, FT, GT, 1'b0, 1'b0, exp_rc));
    sym_burst(16);
    check("neg_err_lock", snap());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
